// File: rtl/clock_time_ctrl.sv
// BCD hh:mm:ss clock with a RUN / SET_HOUR / SET_MIN mode FSM and an hourly chime.
// Every output is a flop; all six digits update together on a single edge.
module clock_time_ctrl #(
  parameter bit H24 = 1'b1
) (
  input  logic       clk,
  input  logic       cr,
  input  logic       tick_1hz,
  input  logic       key_mode,
  input  logic       key_inc,
  output logic [3:0] sec_lo,
  output logic [3:0] sec_hi,
  output logic [3:0] min_lo,
  output logic [3:0] min_hi,
  output logic [3:0] hour_lo,
  output logic [3:0] hour_hi,
  output logic [1:0] mode,
  output logic       chime
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    SET_HOUR = 2'b01,
    SET_MIN  = 2'b10
  } state_e;

  // Last hour before the wrap, and the hour the counter wraps (and resets) to.
  localparam logic [3:0] HR_MAX_HI = H24 ? 4'd2 : 4'd1;
  localparam logic [3:0] HR_MAX_LO = H24 ? 4'd3 : 4'd2;
  localparam logic [3:0] HR_WRP_LO = H24 ? 4'd0 : 4'd1;
  localparam logic [3:0] HR_RST_HI = H24 ? 4'd0 : 4'd1;
  localparam logic [3:0] HR_RST_LO = H24 ? 4'd0 : 4'd2;

  state_e     state_q, state_d;
  logic [3:0] sec_lo_q, sec_lo_d, sec_hi_q, sec_hi_d;
  logic [3:0] min_lo_q, min_lo_d, min_hi_q, min_hi_d;
  logic [3:0] hour_lo_q, hour_lo_d, hour_hi_q, hour_hi_d;
  logic       chime_q, chime_d;

  logic       sec_wrap, min_wrap;
  logic [3:0] sec_lo_inc, sec_hi_inc, min_lo_inc, min_hi_inc, hour_lo_inc, hour_hi_inc;

  // Incremented values of each field, shared by RUN carries and set-mode keys.
  always_comb begin
    sec_wrap   = (sec_hi_q == 4'd5) && (sec_lo_q == 4'd9);
    min_wrap   = (min_hi_q == 4'd5) && (min_lo_q == 4'd9);
    sec_lo_inc = (sec_lo_q == 4'd9) ? 4'd0 : sec_lo_q + 4'd1;
    sec_hi_inc = (sec_lo_q == 4'd9) ? ((sec_hi_q == 4'd5) ? 4'd0 : sec_hi_q + 4'd1) : sec_hi_q;
    min_lo_inc = (min_lo_q == 4'd9) ? 4'd0 : min_lo_q + 4'd1;
    min_hi_inc = (min_lo_q == 4'd9) ? ((min_hi_q == 4'd5) ? 4'd0 : min_hi_q + 4'd1) : min_hi_q;
    if ((hour_hi_q == HR_MAX_HI) && (hour_lo_q == HR_MAX_LO)) begin
      hour_hi_inc = 4'd0;
      hour_lo_inc = HR_WRP_LO;
    end else if (hour_lo_q == 4'd9) begin
      hour_hi_inc = hour_hi_q + 4'd1;
      hour_lo_inc = 4'd0;
    end else begin
      hour_hi_inc = hour_hi_q;
      hour_lo_inc = hour_lo_q + 4'd1;
    end
  end

  always_comb begin
    state_d   = state_q;
    sec_lo_d  = sec_lo_q;
    sec_hi_d  = sec_hi_q;
    min_lo_d  = min_lo_q;
    min_hi_d  = min_hi_q;
    hour_lo_d = hour_lo_q;
    hour_hi_d = hour_hi_q;
    chime_d   = 1'b0;
    // key_mode wins over both tick_1hz and key_inc in every state.
    unique case (state_q)
      RUN: begin
        if (key_mode) begin
          state_d = SET_HOUR;
        end else if (tick_1hz) begin
          sec_lo_d = sec_lo_inc;
          sec_hi_d = sec_hi_inc;
          if (sec_wrap) begin
            min_lo_d = min_lo_inc;
            min_hi_d = min_hi_inc;
            if (min_wrap) begin
              hour_lo_d = hour_lo_inc;
              hour_hi_d = hour_hi_inc;
              chime_d   = 1'b1;
            end
          end
        end
      end
      SET_HOUR: begin
        if (key_mode) begin
          state_d = SET_MIN;
        end else if (key_inc) begin
          hour_lo_d = hour_lo_inc;
          hour_hi_d = hour_hi_inc;
        end
      end
      SET_MIN: begin
        if (key_mode) begin
          state_d  = RUN;
          sec_lo_d = 4'd0;
          sec_hi_d = 4'd0;
        end else if (key_inc) begin
          min_lo_d = min_lo_inc;
          min_hi_d = min_hi_inc;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (cr) begin
      state_q   <= RUN;
      sec_lo_q  <= 4'd0;
      sec_hi_q  <= 4'd0;
      min_lo_q  <= 4'd0;
      min_hi_q  <= 4'd0;
      hour_lo_q <= HR_RST_LO;
      hour_hi_q <= HR_RST_HI;
      chime_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      sec_lo_q  <= sec_lo_d;
      sec_hi_q  <= sec_hi_d;
      min_lo_q  <= min_lo_d;
      min_hi_q  <= min_hi_d;
      hour_lo_q <= hour_lo_d;
      hour_hi_q <= hour_hi_d;
      chime_q   <= chime_d;
    end
  end

  assign sec_lo  = sec_lo_q;
  assign sec_hi  = sec_hi_q;
  assign min_lo  = min_lo_q;
  assign min_hi  = min_hi_q;
  assign hour_lo = hour_lo_q;
  assign hour_hi = hour_hi_q;
  assign mode    = state_q;
  assign chime   = chime_q;

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Drives a 24-hour and a 12-hour instance with shared inputs; expected outputs
// are queued as each cycle is driven and compared one clock later.
module tb_clock_time_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic cr, tick, km, ki;
  logic [3:0] a_sl, a_sh, a_ml, a_mh, a_hl, a_hh;
  logic [3:0] b_sl, b_sh, b_ml, b_mh, b_hl, b_hh;
  logic [1:0] a_mode, b_mode;
  logic       a_chime, b_chime;

  clock_time_ctrl #(.H24(1'b1)) u_h24 (
    .clk(clk), .cr(cr), .tick_1hz(tick), .key_mode(km), .key_inc(ki),
    .sec_lo(a_sl), .sec_hi(a_sh), .min_lo(a_ml), .min_hi(a_mh),
    .hour_lo(a_hl), .hour_hi(a_hh), .mode(a_mode), .chime(a_chime)
  );

  clock_time_ctrl #(.H24(1'b0)) u_h12 (
    .clk(clk), .cr(cr), .tick_1hz(tick), .key_mode(km), .key_inc(ki),
    .sec_lo(b_sl), .sec_hi(b_sh), .min_lo(b_ml), .min_hi(b_mh),
    .hour_lo(b_hl), .hour_hi(b_hh), .mode(b_mode), .chime(b_chime)
  );

  typedef struct {
    string tag;
    int mode, h24, h12, m, s, chime;
  } exp_t;

  typedef struct {
    logic cr, t, km, ki;
    int mode, h24, h12, m, s, chime;
  } vec_t;

  exp_t sb_q[$];
  vec_t tab[13];
  int n_tests = 0;
  int n_fail  = 0;

  // Reference clock kept as plain integers.
  int md_mode = 0, md_h24 = 0, md_h12 = 12, md_m = 0, md_s = 0, md_chime = 0;

  task automatic model_step(input logic c, input logic t, input logic k, input logic i);
    md_chime = 0;
    if (c) begin
      md_mode = 0; md_h24 = 0; md_h12 = 12; md_m = 0; md_s = 0;
    end else if (k) begin
      if (md_mode == 2) md_s = 0;
      md_mode = (md_mode + 1) % 3;
    end else if (md_mode == 0 && t) begin
      md_s = md_s + 1;
      if (md_s == 60) begin
        md_s = 0;
        md_m = md_m + 1;
        if (md_m == 60) begin
          md_m     = 0;
          md_h24   = (md_h24 + 1) % 24;
          md_h12   = (md_h12 == 12) ? 1 : md_h12 + 1;
          md_chime = 1;
        end
      end
    end else if (md_mode == 1 && i) begin
      md_h24 = (md_h24 + 1) % 24;
      md_h12 = (md_h12 == 12) ? 1 : md_h12 + 1;
    end else if (md_mode == 2 && i) begin
      md_m = (md_m + 1) % 60;
    end
  endtask

  function automatic logic [26:0] pack(input int mo, input int h, input int m, input int s, input int ch);
    return {2'(mo), 4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 1'(ch)};
  endfunction

  task automatic check_one(input exp_t e);
    logic [26:0] got, want;
    got  = {a_mode, a_hh, a_hl, a_mh, a_ml, a_sh, a_sl, a_chime};
    want = pack(e.mode, e.h24, e.m, e.s, e.chime);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s h24: got mode/hhmmss/chime %h want %h", e.tag, got, want);
    end
    got  = {b_mode, b_hh, b_hl, b_mh, b_ml, b_sh, b_sl, b_chime};
    want = pack(e.mode, e.h12, e.m, e.s, e.chime);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s h12: got mode/hhmmss/chime %h want %h", e.tag, got, want);
    end
  endtask

  // Check whatever was queued last cycle, then drive this cycle and queue its result.
  task automatic cycle(input logic c, input logic t, input logic k, input logic i,
                       input string tag, input bit use_tab, input vec_t v);
    exp_t e;
    @(negedge clk);
    if (sb_q.size() > 0) check_one(sb_q.pop_front());
    cr = c; tick = t; km = k; ki = i;
    model_step(c, t, k, i);
    if (use_tab) e = '{tag, v.mode, v.h24, v.h12, v.m, v.s, v.chime};
    else         e = '{tag, md_mode, md_h24, md_h12, md_m, md_s, md_chime};
    sb_q.push_back(e);
  endtask

  vec_t nv;
  task automatic go(input logic c, input logic t, input logic k, input logic i, input string tag);
    cycle(c, t, k, i, tag, 1'b0, nv);
  endtask

  task automatic rep(input int n, input logic t, input logic k, input logic i, input string tag);
    for (int j = 0; j < n; j++) go(1'b0, t, k, i, tag);
  endtask

  initial begin
    cr = 1'b1; tick = 1'b0; km = 1'b0; ki = 1'b0;
    nv = '{1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0};
    //          cr    tick  km    ki    mode h24 h12 m  s  chime
    tab[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0,   0,  12, 0, 0, 0};
    tab[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 0,   0,  12, 0, 1, 0};
    tab[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 0,   0,  12, 0, 1, 0};
    tab[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1,   0,  12, 0, 1, 0};
    tab[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1,   1,  1,  0, 1, 0};
    tab[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1,   1,  1,  0, 1, 0};
    tab[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 2,   1,  1,  0, 1, 0};
    tab[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2,   1,  1,  1, 1, 0};
    tab[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 0,   1,  1,  1, 0, 0};
    tab[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 0,   0,  12, 0, 0, 0};
    tab[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1,   0,  12, 0, 0, 0};
    tab[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 2,   0,  12, 0, 0, 0};
    tab[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 0,   0,  12, 0, 0, 0};
    for (int r = 0; r < 13; r++)
      cycle(tab[r].cr, tab[r].t, tab[r].km, tab[r].ki, $sformatf("tab%0d", r), 1'b1, tab[r]);

    // Reset then a minute of ticks: 00:01:00, no chime.
    go(1'b1, 1'b0, 1'b0, 1'b0, "rst");
    rep(60, 1'b1, 1'b0, 1'b0, "tick60");
    go(1'b0, 1'b0, 1'b0, 1'b0, "idle");

    // Preload 23:59 (12h: 11:59), tick to :59, then the rollover tick.
    go(1'b1, 1'b0, 1'b0, 1'b0, "rst2");
    go(1'b0, 1'b0, 1'b1, 1'b0, "to_seth");
    rep(23, 1'b0, 1'b0, 1'b1, "inc_h");
    go(1'b0, 1'b0, 1'b1, 1'b0, "to_setm");
    rep(59, 1'b0, 1'b0, 1'b1, "inc_m");
    go(1'b0, 1'b0, 1'b1, 1'b0, "to_run");
    rep(59, 1'b1, 1'b0, 1'b0, "tick59");
    go(1'b0, 1'b1, 1'b0, 1'b0, "rollover");
    rep(3, 1'b0, 1'b0, 1'b0, "post_roll");

    // 12h instance now at 12:00: set :59, run to 12:59:59, roll to 01:00:00.
    rep(2, 1'b0, 1'b1, 1'b0, "to_setm2");
    rep(59, 1'b0, 1'b0, 1'b1, "inc_m2");
    go(1'b0, 1'b0, 1'b1, 1'b0, "to_run2");
    rep(59, 1'b1, 1'b0, 1'b0, "tick59b");
    go(1'b0, 1'b1, 1'b0, 1'b0, "rollover12");
    rep(2, 1'b0, 1'b0, 1'b0, "post_roll2");

    // Set-mode edits: +5 hours, 61 minute steps, ticks frozen, exit clears seconds.
    rep(7, 1'b1, 1'b0, 1'b0, "pre_set");
    go(1'b0, 1'b0, 1'b1, 1'b0, "seth");
    rep(5, 1'b0, 1'b0, 1'b1, "h_plus5");
    rep(3, 1'b1, 1'b0, 1'b0, "frozen_h");
    go(1'b0, 1'b0, 1'b1, 1'b0, "setm");
    rep(61, 1'b0, 1'b0, 1'b1, "m_plus61");
    rep(3, 1'b1, 1'b0, 1'b0, "frozen_m");
    go(1'b0, 1'b0, 1'b1, 1'b0, "exit_set");

    // Reset mid-set with key_inc high.
    rep(2, 1'b0, 1'b1, 1'b0, "to_setm3");
    go(1'b1, 1'b0, 1'b0, 1'b1, "rst_in_set");
    go(1'b0, 1'b0, 1'b0, 1'b1, "after_rst");

    // Random mix of all inputs.
    for (int n = 0; n < 400; n++)
      go(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 2) == 0),
         1'($urandom_range(0, 24) == 0), 1'($urandom_range(0, 3) == 0), "rand");

    @(negedge clk);
    if (sb_q.size() > 0) check_one(sb_q.pop_front());
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/clock_time_ctrl.md
CLOCK_TIME_CTRL -- requirements
Module: clock_time_ctrl

Interface
REQ-001 Parameter H24, default 1, selects hour format: 1 means 24-hour (00..23); 0 means 12-hour (01..12).
REQ-002 Port clk, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-003 Port cr, input, 1 bit: reset, synchronous, active-high.
REQ-004 Port tick_1hz, input, 1 bit: one-cycle timebase pulse, at most one per second.
REQ-005 Port key_mode, input, 1 bit: one-cycle debounced mode-key pulse.
REQ-006 Port key_inc, input, 1 bit: one-cycle debounced increment-key pulse.
REQ-007 Port sec_lo, output, 4 bits: seconds units, BCD 0..9.
REQ-008 Port sec_hi, output, 4 bits: seconds tens, BCD 0..5.
REQ-009 Port min_lo, output, 4 bits: minutes units, BCD 0..9.
REQ-010 Port min_hi, output, 4 bits: minutes tens, BCD 0..5.
REQ-011 Port hour_lo, output, 4 bits: hours units, BCD.
REQ-012 Port hour_hi, output, 4 bits: hours tens, BCD 0..2.
REQ-013 Port mode, output, 2 bits: 00 RUN, 01 SET_HOUR, 10 SET_MIN; 11 is never driven.
REQ-014 Port chime, output, 1 bit: one-cycle pulse on each hour rollover.

Function
REQ-015 The block SHALL implement a 3-state FSM with states RUN, SET_HOUR and SET_MIN; key_mode advances it RUN->SET_HOUR->SET_MIN->RUN, one step per pulse.
REQ-016 All outputs SHALL be registered; an event sampled at edge N is visible after edge N.
REQ-017 In RUN, each tick_1hz SHALL increment seconds 00..59; a tick at second 59 SHALL wrap seconds to 00 and carry into minutes in the same edge.
REQ-018 Minutes SHALL count 00..59; a carry at minute 59 SHALL wrap minutes to 00 and carry into hours in the same edge.
REQ-019 When H24=1, hours SHALL count 00..23 and wrap from 23 to 00.
REQ-020 When H24=0, hours SHALL count 01..12 and wrap from 12 to 01.
REQ-021 A tick at xx:59:59 SHALL update all six digits in a single edge; no intermediate value is ever visible.
REQ-022 chime SHALL pulse for exactly one cycle, coincident with the digits first showing yy:00:00 after a RUN tick rollover; chime SHALL be 0 at all other times.
REQ-023 In SET_HOUR, key_inc SHALL increment hours with the same wrap rule as RUN and no carry; minutes and seconds hold.
REQ-024 In SET_MIN, key_inc SHALL increment minutes 00..59 with wrap and no carry into hours; hours and seconds hold.
REQ-025 In SET_HOUR and SET_MIN, tick_1hz SHALL be ignored, so the time is frozen.
REQ-026 The SET_MIN->RUN transition SHALL clear seconds to 00 in the same edge.
REQ-027 When key_mode and key_inc arrive in the same cycle, key_mode SHALL take priority and the increment is discarded.
REQ-028 When key_mode and tick_1hz arrive in the same cycle in RUN, the FSM SHALL enter SET_HOUR and the tick is discarded.
REQ-029 key_inc in RUN SHALL have no effect.
REQ-030 A set-mode increment SHALL never assert chime.
REQ-031 Digit registers SHALL never hold a non-BCD value or an out-of-range time.

Reset
REQ-032 When cr=1 at a clk edge, the block SHALL reset: mode=00 (RUN), seconds=00, minutes=00, chime=0.
REQ-033 On reset, hours SHALL be 00 when H24=1 and 12 when H24=0.
REQ-034 Reset SHALL override every simultaneous input event.
REQ-035 Reset asserted mid-set SHALL return the block to RUN, discarding pending edits.
REQ-036 Inputs sampled in the first cycle after cr deasserts SHALL be acted on normally.

Verification
REQ-037 H24=1, reset, 60 ticks -> 00:01:00; chime stays 0 throughout.
REQ-038 H24=1, preload 23:59:59 via set mode (then tick to :59), one tick -> 00:00:00 in one edge; chime=1 for exactly one cycle.
REQ-039 H24=0, after reset hours=12; drive to 12:59:59, one tick -> 01:00:00 with chime pulse.
REQ-040 From RUN: key_mode, then 5 key_inc -> hours +5 with wrap; key_mode, then 61 key_inc -> minutes +1 net, hours unchanged; ticks during set -> no change; key_mode -> RUN with seconds=00.
REQ-041 key_mode and key_inc in the same cycle in SET_HOUR -> mode=10, hours unchanged; key_mode and tick in the same cycle in RUN -> mode=01, seconds unchanged.
REQ-042 cr=1 while in SET_MIN with key_inc high -> next cycle mode=00, time 00:00:00 (or 12:00:00 when H24=0), chime=0.
